a09_boot_loader: RTL and testbench

//  Upstream of the A09 CPU. Receives a framed byte stream, packs bytes into

---
 rtl/a09_boot_loader_pkg.sv | 21 ++
 rtl/a09_boot_loader_word_assembler.sv | 47 ++++
 rtl/a09_boot_loader.sv | 128 ++++++++++++
 tb/tb_a09_boot_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/a09_boot_loader_pkg.sv
// Shared constants for the A09 boot loader: FSM encodings, default sync byte, word packing.
// Optional checksum support in the top is controlled by A09_BOOT_CHECKSUM_EN.
package a09_boot_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CSUM  = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA9;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/a09_boot_loader_word_assembler.sv
// Packs incoming bytes into a DataWidth word, low byte first.
// last_byte flags that the next shift completes a word; word_full marks a completed word.
module a09_boot_loader_word_assembler
  import a09_boot_loader_pkg::*;
#(
  parameter int DataWidth = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 clear,
  input  logic                 shift,
  input  logic [7:0]           byte_in,
  output logic [DataWidth-1:0] word,
  output logic                 last_byte,
  output logic                 word_full
);

  localparam int BPW = bytes_per_word(DataWidth);
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [CW-1:0]        cnt;
  logic [DataWidth-1:0] word_shifted;

  // New bytes enter at the top so the first byte received ends up in the low lane.
  generate
    if (BPW > 1) begin : g_multi
      assign word_shifted = {byte_in, word[DataWidth-1:8]};
    end else begin : g_single
      assign word_shifted = byte_in;
    end
  endgenerate

  assign last_byte = (cnt == CW'(BPW - 1));

  always_ff @(posedge Clk) begin
    if (Reset || clear) begin
      word      <= '0;
      cnt       <= '0;
      word_full <= 1'b0;
    end else if (shift) begin
      word      <= word_shifted;
      word_full <= last_byte;
      cnt       <= last_byte ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/a09_boot_loader.sv
// A09 boot loader: framed byte stream -> program memory words, releases CPU reset on success.
// Define A09_BOOT_CHECKSUM_EN to enable the trailing checksum byte and the Error output.
module a09_boot_loader
  import a09_boot_loader_pkg::*;
#(
  parameter int                   DataWidth = 16,
  parameter int                   AddrWidth = 8,
  parameter logic [AddrWidth-1:0] BaseAddr  = '0,
  parameter logic [7:0]           SyncByte  = SYNC_BYTE_DEFAULT
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [7:0]           RX_Data,
  input  logic                 RX_Valid,
  output logic                 RX_Ready,
  output logic [AddrWidth-1:0] Mem_Addr,
  output logic [DataWidth-1:0] Mem_Data,
  output logic                 Mem_WE,
  output logic                 CPU_Reset,
  output logic                 Done,
  output logic                 Error,
  output logic [2:0]           dbg_state
);

  // Byte handshake: a byte transfers on a rising Clk edge where RX_Valid and
  // RX_Ready are both high; the sender holds RX_Data until then.

`ifdef A09_BOOT_CHECKSUM_EN
  localparam state_t END_STATE = S_CSUM;
`else
  localparam state_t END_STATE = S_DONE;
`endif

  state_t               state, state_next;
  logic                 accept;
  logic [7:0]           n_words;
  logic [7:0]           index;
  logic [7:0]           index_inc;
  logic [AddrWidth-1:0] mem_addr;
  logic [DataWidth-1:0] asm_word;
  logic                 asm_last;
  logic                 asm_full;
`ifdef A09_BOOT_CHECKSUM_EN
  logic [7:0]           sum;
`endif

  assign accept    = RX_Valid && RX_Ready;
  assign index_inc = index + 8'd1;

  a09_boot_loader_word_assembler #(
    .DataWidth(DataWidth)
  ) u_word_assembler (
    .Clk      (Clk),
    .Reset    (Reset),
    .clear    (state == S_LEN),
    .shift    ((state == S_DATA) && accept),
    .byte_in  (RX_Data),
    .word     (asm_word),
    .last_byte(asm_last),
    .word_full(asm_full)
  );

  always_comb begin
    RX_Ready = 1'b0;
    case (state)
      S_IDLE, S_LEN, S_DATA, S_CSUM, S_ERROR: RX_Ready = 1'b1;
      default:                                RX_Ready = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept && (RX_Data == SyncByte)) state_next = S_LEN;
      S_LEN:   if (accept) state_next = (RX_Data == 8'd0) ? END_STATE : S_DATA;
      S_DATA:  if (accept && asm_last) state_next = S_WRITE;
      S_WRITE: state_next = (index_inc == n_words) ? END_STATE : S_DATA;
`ifdef A09_BOOT_CHECKSUM_EN
      S_CSUM:  if (accept) state_next = (RX_Data == sum) ? S_DONE : S_ERROR;
`endif
      S_DONE:  state_next = S_DONE;
      S_ERROR: if (accept && (RX_Data == SyncByte)) state_next = S_LEN;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= S_IDLE;
      n_words  <= '0;
      index    <= '0;
      mem_addr <= '0;
`ifdef A09_BOOT_CHECKSUM_EN
      sum      <= '0;
`endif
    end else begin
      state <= state_next;
      if ((state == S_LEN) && accept) begin
        n_words <= RX_Data;
        index   <= '0;
`ifdef A09_BOOT_CHECKSUM_EN
        sum     <= '0;
`endif
      end
      if ((state == S_DATA) && accept) begin
`ifdef A09_BOOT_CHECKSUM_EN
        sum <= sum + RX_Data;
`endif
        // Address is captured as the word completes so it is stable for the WRITE cycle.
        if (asm_last) mem_addr <= BaseAddr + AddrWidth'(index);
      end
      if (state == S_WRITE) index <= index_inc;
    end
  end

  assign Mem_WE    = (state == S_WRITE) && asm_full;
  assign Mem_Addr  = mem_addr;
  assign Mem_Data  = asm_word;
  assign CPU_Reset = (state != S_DONE);
  assign Done      = (state == S_DONE);
`ifdef A09_BOOT_CHECKSUM_EN
  assign Error     = (state == S_ERROR);
`else
  assign Error     = 1'b0;
`endif
  assign dbg_state = state;

endmodule

// File: tb/tb_a09_boot_loader.sv
// Directed bench for a09_boot_loader: two instances (BaseAddr 0 and 8'hFF), write scoreboard.
// Follows the build's A09_BOOT_CHECKSUM_EN setting for frame format and error tests.
module tb_a09_boot_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data_a, rx_data_b;
  logic        rx_valid_a, rx_valid_b;
  logic        rx_ready_a, rx_ready_b;
  logic [7:0]  mem_addr_a, mem_addr_b;
  logic [15:0] mem_data_a, mem_data_b;
  logic        mem_we_a, mem_we_b;
  logic        cpu_reset_a, cpu_reset_b;
  logic        done_a, done_b;
  logic        error_a, error_b;
  logic [2:0]  dbg_state_a, dbg_state_b;

  int n_assert = 0;
  int n_fail   = 0;
  int stall_b  = 0;

  logic [23:0] exp_q_a[$];
  logic [23:0] exp_q_b[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  a09_boot_loader #(.DataWidth(16), .AddrWidth(8), .BaseAddr(8'h00)) dut_a (
    .Clk(clk), .Reset(reset), .RX_Data(rx_data_a), .RX_Valid(rx_valid_a), .RX_Ready(rx_ready_a),
    .Mem_Addr(mem_addr_a), .Mem_Data(mem_data_a), .Mem_WE(mem_we_a), .CPU_Reset(cpu_reset_a),
    .Done(done_a), .Error(error_a), .dbg_state(dbg_state_a)
  );

  a09_boot_loader #(.DataWidth(16), .AddrWidth(8), .BaseAddr(8'hFF)) dut_b (
    .Clk(clk), .Reset(reset), .RX_Data(rx_data_b), .RX_Valid(rx_valid_b), .RX_Ready(rx_ready_b),
    .Mem_Addr(mem_addr_b), .Mem_Data(mem_data_b), .Mem_WE(mem_we_b), .CPU_Reset(cpu_reset_b),
    .Done(done_b), .Error(error_b), .dbg_state(dbg_state_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reset_all();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input int d, input logic [7:0] b, input logic v);
    if (d == 0) begin rx_data_a = b; rx_valid_a = v; end
    else        begin rx_data_b = b; rx_valid_b = v; end
  endtask

  function automatic logic get_ready(input int d);
    return (d == 0) ? rx_ready_a : rx_ready_b;
  endfunction
  function automatic logic get_done(input int d);
    return (d == 0) ? done_a : done_b;
  endfunction
  function automatic logic get_cpu_reset(input int d);
    return (d == 0) ? cpu_reset_a : cpu_reset_b;
  endfunction
  function automatic logic get_error(input int d);
    return (d == 0) ? error_a : error_b;
  endfunction
  function automatic logic get_we(input int d);
    return (d == 0) ? mem_we_a : mem_we_b;
  endfunction

  // Called at a negedge; returns at the negedge after the byte was accepted, RX_Valid still high.
  task automatic send_byte(input int d, input logic [7:0] b);
    int guard = 0;
    set_in(d, b, 1'b1);
    while (!get_ready(d) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (d == 1) stall_b += guard;
    chk("rx_ready_wait", get_ready(d), 1'b1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_frame(input int d, input logic [7:0] cs);
    logic [7:0] fr[6] = '{8'hA9, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56};
    for (int i = 0; i < 6; i++) send_byte(d, fr[i]);
`ifdef A09_BOOT_CHECKSUM_EN
    send_byte(d, cs);
`endif
  endtask

  task automatic push_good_writes(input int d, input logic [7:0] base);
    logic [7:0] a1;
    a1 = base + 8'd1;
    if (d == 0) begin exp_q_a.push_back({base, 16'h1234}); exp_q_a.push_back({a1, 16'h5678}); end
    else        begin exp_q_b.push_back({base, 16'h1234}); exp_q_b.push_back({a1, 16'h5678}); end
  endtask

  // At the negedge right after the final accepted byte of a good frame.
  task automatic check_frame_end(input int d);
    set_in(d, 8'h00, 1'b0);
`ifdef A09_BOOT_CHECKSUM_EN
    chk("done_after_csum", get_done(d), 1'b1);
`else
    chk("we_after_last_byte", get_we(d), 1'b1);
    chk("done_not_yet", get_done(d), 1'b0);
    @(negedge clk);
    chk("done_after_write", get_done(d), 1'b1);
`endif
    chk("cpu_reset_released", get_cpu_reset(d), 1'b0);
    chk("error_clear", get_error(d), 1'b0);
    chk("ready_low_in_done", get_ready(d), 1'b0);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (mem_we_a) begin
      chk("mem_write_a", {mem_addr_a, mem_data_a}, (exp_q_a.size() != 0) ? exp_q_a.pop_front() : 24'hxxxxxx);
      chk("ready_low_in_write_a", rx_ready_a, 1'b0);
    end
    if (mem_we_b) begin
      chk("mem_write_b", {mem_addr_b, mem_data_b}, (exp_q_b.size() != 0) ? exp_q_b.pop_front() : 24'hxxxxxx);
      chk("ready_low_in_write_b", rx_ready_b, 1'b0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    set_in(0, 8'h00, 1'b0);
    set_in(1, 8'h00, 1'b0);
    @(negedge clk);

    // Test 1: reset values
    reset_all();
    chk("rst_cpu_reset_a", cpu_reset_a, 1'b1);
    chk("rst_we_a", mem_we_a, 1'b0);
    chk("rst_done_a", done_a, 1'b0);
    chk("rst_error_a", error_a, 1'b0);
    chk("rst_ready_a", rx_ready_a, 1'b1);
    chk("rst_addr_a", mem_addr_a, 8'h00);
    chk("rst_data_a", mem_data_a, 16'h0000);
    chk("rst_state_a", dbg_state_a, 3'd0);
    chk("rst_addr_b", mem_addr_b, 8'h00);
    chk("rst_cpu_reset_b", cpu_reset_b, 1'b1);

    // Test 2: good frame
    push_good_writes(0, 8'h00);
    send_frame(0, 8'h14);
    check_frame_end(0);

    // Test 3: junk before the frame
    reset_all();
    send_byte(0, 8'h00);
    send_byte(0, 8'hFF);
    set_in(0, 8'h00, 1'b0);
    @(negedge clk);
    chk("junk_state_idle", dbg_state_a, 3'd0);
    push_good_writes(0, 8'h00);
    send_frame(0, 8'h14);
    check_frame_end(0);

    // Test 4
    reset_all();
`ifdef A09_BOOT_CHECKSUM_EN
    push_good_writes(0, 8'h00);
    send_frame(0, 8'h15);
    set_in(0, 8'h00, 1'b0);
    chk("bad_csum_error", error_a, 1'b1);
    chk("bad_csum_cpu_reset", cpu_reset_a, 1'b1);
    chk("bad_csum_done", done_a, 1'b0);
    chk("bad_csum_ready", rx_ready_a, 1'b1);
    push_good_writes(0, 8'h00);
    send_frame(0, 8'h14);
    check_frame_end(0);
`else
    send_byte(0, 8'hA9);
    send_byte(0, 8'h00);
    set_in(0, 8'h00, 1'b0);
    chk("empty_frame_done", done_a, 1'b1);
    chk("empty_frame_cpu_reset", cpu_reset_a, 1'b0);
    chk("empty_frame_error", error_a, 1'b0);
`endif

    // Test 5: reset mid-frame
    reset_all();
    exp_q_a.push_back({8'h00, 16'h1234});
    send_byte(0, 8'hA9);
    send_byte(0, 8'h02);
    send_byte(0, 8'h34);
    send_byte(0, 8'h12);
    send_byte(0, 8'h78);
    set_in(0, 8'h00, 1'b0);
    chk("mid_state_data", dbg_state_a, 3'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_state_idle", dbg_state_a, 3'd0);
    chk("abort_we", mem_we_a, 1'b0);
    chk("abort_done", done_a, 1'b0);
    chk("abort_cpu_reset", cpu_reset_a, 1'b1);
    repeat (4) @(negedge clk);
    push_good_writes(0, 8'h00);
    send_frame(0, 8'h14);
    check_frame_end(0);

    // Test 6: BaseAddr 8'hFF, RX_Valid held high throughout
    push_good_writes(1, 8'hFF);
    send_frame(1, 8'h14);
    check_frame_end(1);
`ifdef A09_BOOT_CHECKSUM_EN
    chk("stall_cycles_b", stall_b, 2);
`else
    chk("stall_cycles_b", stall_b, 1);
`endif

    repeat (3) @(negedge clk);
    chk("exp_q_a_drained", exp_q_a.size(), 0);
    chk("exp_q_b_drained", exp_q_b.size(), 0);
    chk("done_held_a", done_a, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
